one_hot_seq_monitor: RTL and testbench
======================================

Name: one_hot_seq_monitor

Overview:
- Receive-side checker for the 4-state one-hot sequencer bus (state[3:0] one-hot, out[1:0] code).
- Samples the bus and decodes one-hot to binary. Locks onto the legal sequence IDLE→S1→S2→S3→IDLE and flags illegal encodings, skipped or repeated states, and wrong out codes.
- Sits at the consumer end of the sequencer bus and feeds status and error counters to control logic.

Parameters:
- LOCK_CNT, 4: consecutive correct transitions required before locked asserts (≥1).
- CNT_W, 16: width of lap_count and err_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample qualifier; bus is checked only on cycles with en=1.
- state_in  in  4  one-hot state from sequencer (0001=IDLE, 0010=S1, 0100=S2, 1000=S3).
- out_in  in  2  sequencer code; legal value equals index of the previously sampled state.
- clr  in  1  synchronous clear of sticky flag and counters.
- dec_state  out  2  registered binary index of last valid one-hot sample.
- locked  out  1  monitor is tracking a verified sequence.
- err_onehot  out  1  one-cycle pulse: sample not exactly one bit set.
- err_seq  out  1  one-cycle pulse: state_in not the rotate-left of the previous sample (TRACK only).
- err_code  out  1  one-cycle pulse: out_in ≠ previous index (TRACK only).
- err_sticky  out  1  set by any error pulse; cleared by reset or clr.
- lap_count  out  CNT_W  completed S3→IDLE wraps while locked; wraps modulo 2^CNT_W.
- err_count  out  CNT_W  number of error events (one per cycle max); saturates at all-ones.

Behaviour:
- Reset (async) values: all outputs 0, FSM=HUNT, prev_idx=0, good_run=0.
- All outputs are registered. Response appears on the edge that samples the bus, i.e. visible the cycle after the sample.
- en=0: no state change, all error pulses 0, dec_state holds.
- One-hot check in every FSM state. On an invalid sample: err_onehot=1, dec_state holds, FSM→HUNT, locked=0, good_run=0.
- FSM states:
  - HUNT: wait for a valid sample with state_in=0001. Then prev_idx=0, good_run=0, →TRACK. out_in is not checked on this entry sample, since 00 (post-reset) and 11 (wrap) are both legal. Other valid samples only update dec_state and raise no error.
  - TRACK: on each en sample, expected state = rotate-left(one-hot of prev_idx) and expected out_in = prev_idx.
    - Pass: prev_idx ← new index, good_run ← min(good_run+1, LOCK_CNT). locked ← 1 once good_run reaches LOCK_CNT. If locked and the transition was S3→IDLE, lap_count+1.
    - Fail: err_seq and/or err_code pulse (both may assert together), FSM→HUNT, locked=0, good_run=0.
    - A failing sample that is itself 0001 still returns to HUNT; re-entry happens on the next 0001.
- err_count increments by 1 per cycle in which any error pulse is set (not per flag).
- clr=1: lap_count, err_count and err_sticky are cleared; FSM and locked are unaffected. If an error occurs in the same cycle as clr: err_sticky=1 and err_count=1, so the error wins over clear.
- Reset mid-sequence returns to HUNT immediately; the next 0001 sample re-enters TRACK.

Decomposition:
- Shared package:
  - one-hot encodings IDLE/S1/S2/S3 (also used by the sequencer);
  - monitor FSM enum {HUNT, TRACK};
  - function onehot_valid(4b)→1b;
  - function onehot2bin(4b)→2b.
- One natural sub-module: onehot4_decoder (combinational valid + index), reusable elsewhere.
- Counters stay inline.

Test Plan:
- Reset, then drive the legal sequencer pattern for 6 laps with en=1.
  - locked rises 1 cycle after the 4th correct transition.
  - lap_count=5 after the 6th IDLE (first IDLE is entry, not counted), err_count=0.
- While locked, inject state_in=0110 for one cycle.
  - err_onehot pulses 1 cycle, locked=0, err_count=1, err_sticky=1, dec_state unchanged.
  - Relock after the next 0001 plus 4 correct transitions.
- While locked, skip S2 (0010→1000, out_in correct for S1).
  - err_seq=1, err_code=0, FSM HUNT, err_count+1.
- While locked, drive correct state but out_in=11 where 01 is expected.
  - err_code=1 only.
  - Same cycle as clr=1: err_count=1 and err_sticky=1 afterwards.
- Hold en=0 for 10 cycles mid-lap while the bus freezes, then resume.
  - No errors, locked stays 1, lap counting continues.
- Preload err_count to all-ones via a forced error stream (CNT_W=4: 20 errors).
  - err_count saturates at 15.
  - lap_count with CNT_W=4 wraps 15→0.

Source files
------------

// File: rtl/one_hot_seq_monitor_pkg.sv
// Shared definitions for the 4-state one-hot sequencer bus and its receive-side monitor.
// Holds the bus encodings, the monitor FSM states and the one-hot helper functions.
package one_hot_seq_monitor_pkg;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_S1   = 4'b0010;
    localparam logic [3:0] ST_S2   = 4'b0100;
    localparam logic [3:0] ST_S3   = 4'b1000;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

    function automatic logic onehot_valid(input logic [3:0] code);
        return (code != 4'b0000) && ((code & (code - 4'd1)) == 4'b0000);
    endfunction

    // Index of the highest set bit; only meaningful when onehot_valid() is true.
    function automatic logic [1:0] onehot2bin(input logic [3:0] code);
        logic [1:0] idx;
        if (code[3]) begin
            idx = 2'd3;
        end else if (code[2]) begin
            idx = 2'd2;
        end else if (code[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/one_hot_seq_monitor_decoder.sv
// Combinational 4-bit one-hot decoder: validity flag plus binary index.
// Kept stand-alone so other consumers of the sequencer bus can reuse it.
module onehot4_decoder
    import one_hot_seq_monitor_pkg::*;
(
    input  logic [3:0] code,
    output logic       valid,
    output logic [1:0] idx
);

    assign valid = onehot_valid(code);
    assign idx   = onehot2bin(code);

endmodule

// File: rtl/one_hot_seq_monitor.sv
// Receive-side checker for the one-hot sequencer bus: locks onto IDLE->S1->S2->S3->IDLE,
// reports encoding, sequence and code errors, and keeps lap and error counters.
module one_hot_seq_monitor
    import one_hot_seq_monitor_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       state_in,
    input  logic [1:0]       out_in,
    input  logic             clr,
    output logic [1:0]       dec_state,
    output logic             locked,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] lap_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int                RUN_W    = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic       sample_valid;
    logic [1:0] sample_idx;

    onehot4_decoder u_decoder (
        .code  (state_in),
        .valid (sample_valid),
        .idx   (sample_idx)
    );

    mon_state_t       state_reg, state_next;
    logic [1:0]       prev_idx_reg, prev_idx_next;
    logic [RUN_W-1:0] good_run_reg, good_run_next;
    logic [1:0]       dec_state_reg, dec_state_next;
    logic             locked_reg, locked_next;
    logic             err_onehot_reg, err_onehot_next;
    logic             err_seq_reg, err_seq_next;
    logic             err_code_reg, err_code_next;
    logic             err_sticky_reg, err_sticky_next;
    logic [CNT_W-1:0] lap_count_reg, lap_count_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;

    logic             lap_inc;
    logic             any_err;
    logic             seq_bad;
    logic             code_bad;
    logic [CNT_W-1:0] err_base;

    always_comb begin
        state_next      = state_reg;
        prev_idx_next   = prev_idx_reg;
        good_run_next   = good_run_reg;
        dec_state_next  = dec_state_reg;
        locked_next     = locked_reg;
        err_onehot_next = 1'b0;
        err_seq_next    = 1'b0;
        err_code_next   = 1'b0;
        lap_inc         = 1'b0;
        // Rotate-left of a one-hot value is simply index + 1 modulo 4.
        seq_bad         = sample_idx != (prev_idx_reg + 2'd1);
        code_bad        = out_in != prev_idx_reg;

        if (en) begin
            if (!sample_valid) begin
                err_onehot_next = 1'b1;
                state_next      = HUNT;
                locked_next     = 1'b0;
                good_run_next   = '0;
            end else begin
                dec_state_next = sample_idx;
                case (state_reg)
                    HUNT: begin
                        // out_in is ignored on entry: 00 after reset and 11 on wrap are both legal.
                        if (sample_idx == 2'd0) begin
                            prev_idx_next = 2'd0;
                            good_run_next = '0;
                            state_next    = TRACK;
                        end
                    end
                    TRACK: begin
                        if (seq_bad || code_bad) begin
                            err_seq_next  = seq_bad;
                            err_code_next = code_bad;
                            state_next    = HUNT;
                            locked_next   = 1'b0;
                            good_run_next = '0;
                        end else begin
                            prev_idx_next = sample_idx;
                            if (good_run_reg < RUN_MAX) begin
                                good_run_next = good_run_reg + RUN_ONE;
                            end
                            if (good_run_next == RUN_MAX) begin
                                locked_next = 1'b1;
                            end
                            // The wrap that completes the lock already counts as a lap.
                            lap_inc = locked_next && (prev_idx_reg == 2'd3) && (sample_idx == 2'd0);
                        end
                    end
                    default: state_next = HUNT;
                endcase
            end
        end

        any_err  = err_onehot_next | err_seq_next | err_code_next;
        err_base = clr ? '0 : err_count_reg;

        // A same-cycle error takes priority over clr for the sticky flag and counter.
        err_sticky_next = any_err ? 1'b1 : (clr ? 1'b0 : err_sticky_reg);
        err_count_next  = (any_err && (err_base != '1)) ? err_base + CNT_ONE : err_base;
        lap_count_next  = (clr ? '0 : lap_count_reg) + CNT_W'(lap_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= HUNT;
            prev_idx_reg   <= 2'd0;
            good_run_reg   <= '0;
            dec_state_reg  <= 2'd0;
            locked_reg     <= 1'b0;
            err_onehot_reg <= 1'b0;
            err_seq_reg    <= 1'b0;
            err_code_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
            lap_count_reg  <= '0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            prev_idx_reg   <= prev_idx_next;
            good_run_reg   <= good_run_next;
            dec_state_reg  <= dec_state_next;
            locked_reg     <= locked_next;
            err_onehot_reg <= err_onehot_next;
            err_seq_reg    <= err_seq_next;
            err_code_reg   <= err_code_next;
            err_sticky_reg <= err_sticky_next;
            lap_count_reg  <= lap_count_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign dec_state  = dec_state_reg;
    assign locked     = locked_reg;
    assign err_onehot = err_onehot_reg;
    assign err_seq    = err_seq_reg;
    assign err_code   = err_code_reg;
    assign err_sticky = err_sticky_reg;
    assign lap_count  = lap_count_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_one_hot_seq_monitor.sv
// Directed bench for one_hot_seq_monitor (CNT_W=4 so saturation and lap wrap are reachable).
// A vector table covers lock, error classes, clr and en gating; hand sequences cover the rest.
module tb_one_hot_seq_monitor;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [3:0]       state_in = 4'b0000;
    logic [1:0]       out_in = 2'b00;
    logic             clr = 1'b0;
    logic [1:0]       dec_state;
    logic             locked;
    logic             err_onehot;
    logic             err_seq;
    logic             err_code;
    logic             err_sticky;
    logic [CNT_W-1:0] lap_count;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    one_hot_seq_monitor #(
        .LOCK_CNT (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .state_in   (state_in),
        .out_in     (out_in),
        .clr        (clr),
        .dec_state  (dec_state),
        .locked     (locked),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .lap_count  (lap_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] st;
        logic [1:0] oc;
        logic       clr;
        logic [1:0] dec;
        logic       lk;
        logic       eoh;
        logic       eseq;
        logic       ecode;
        logic       stk;
        logic [3:0] lap;
        logic [3:0] errc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int e, input int s, input int o, input int c,
                                input int d, input int lk, input int eoh, input int es,
                                input int ec, input int stk, input int lap, input int errc);
        vec_t v;
        v.en = 1'(e);     v.st = 4'(s);      v.oc = 2'(o);     v.clr = 1'(c);
        v.dec = 2'(d);    v.lk = 1'(lk);     v.eoh = 1'(eoh);  v.eseq = 1'(es);
        v.ecode = 1'(ec); v.stk = 1'(stk);   v.lap = 4'(lap);  v.errc = 4'(errc);
        vecs.push_back(v);
    endfunction

    task automatic check(input string tag, input vec_t v);
        logic [14:0] got;
        logic [14:0] exp;
        got = {dec_state, locked, err_onehot, err_seq, err_code, err_sticky, lap_count, err_count};
        exp = {v.dec, v.lk, v.eoh, v.eseq, v.ecode, v.stk, v.lap, v.errc};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got dec=%0d lk=%b oh=%b seq=%b code=%b stk=%b lap=%0d errc=%0d, want dec=%0d lk=%b oh=%b seq=%b code=%b stk=%b lap=%0d errc=%0d",
                     tag, dec_state, locked, err_onehot, err_seq, err_code, err_sticky, lap_count, err_count,
                     v.dec, v.lk, v.eoh, v.eseq, v.ecode, v.stk, v.lap, v.errc);
        end else begin
            $display("ok   %s: st=%b out=%0d en=%b clr=%b -> dec=%0d lk=%b lap=%0d errc=%0d",
                     tag, state_in, out_in, en, clr, dec_state, locked, lap_count, err_count);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        en       = v.en;
        state_in = v.st;
        out_in   = v.oc;
        clr      = v.clr;
        @(posedge clk);
        #1;
        check(tag, v);
    endtask

    task automatic step(input string tag, input int e, input int s, input int o, input int c,
                        input int d, input int lk, input int eoh, input int es,
                        input int ec, input int stk, input int lap, input int errc);
        vec_t v;
        v.en = 1'(e);     v.st = 4'(s);      v.oc = 2'(o);     v.clr = 1'(c);
        v.dec = 2'(d);    v.lk = 1'(lk);     v.eoh = 1'(eoh);  v.eseq = 1'(es);
        v.ecode = 1'(ec); v.stk = 1'(stk);   v.lap = 4'(lap);  v.errc = 4'(errc);
        apply(tag, v);
    endtask

    initial begin
        vec_t rst_v;

        // Legal laps: entry IDLE, lock on the 4th transition (which is also lap 1), up to the 6th IDLE.
        add(1, 4'b0001, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0100, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1000, 2, 0,  3, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 0, 1, 0);
        for (int l = 2; l <= 5; l++) begin
            add(1, 4'b0010, 0, 0,  1, 1, 0, 0, 0, 0, l - 1, 0);
            add(1, 4'b0100, 1, 0,  2, 1, 0, 0, 0, 0, l - 1, 0);
            add(1, 4'b1000, 2, 0,  3, 1, 0, 0, 0, 0, l - 1, 0);
            add(1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 0, l, 0);
        end
        // Illegal encoding while locked, then hunt and relock.
        add(1, 4'b0110, 0, 0,  0, 0, 1, 0, 0, 1, 5, 1);
        add(1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b0100, 1, 0,  2, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b1000, 2, 0,  3, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b0001, 3, 0,  0, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b0100, 1, 0,  2, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b1000, 2, 0,  3, 0, 0, 0, 0, 1, 5, 1);
        add(1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 1, 6, 1);
        // Skipped S2 with a correct code.
        add(1, 4'b0010, 0, 0,  1, 1, 0, 0, 0, 1, 6, 1);
        add(1, 4'b1000, 1, 0,  3, 0, 0, 1, 0, 1, 6, 2);
        // Relock, then a wrong code in the same cycle as clr, then a plain clr.
        add(1, 4'b0001, 3, 0,  0, 0, 0, 0, 0, 1, 6, 2);
        add(1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 1, 6, 2);
        add(1, 4'b0100, 1, 0,  2, 0, 0, 0, 0, 1, 6, 2);
        add(1, 4'b1000, 2, 0,  3, 0, 0, 0, 0, 1, 6, 2);
        add(1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 1, 7, 2);
        add(1, 4'b0010, 0, 0,  1, 1, 0, 0, 0, 1, 7, 2);
        add(1, 4'b0100, 3, 1,  2, 0, 0, 0, 1, 1, 0, 1);
        add(0, 4'b0100, 3, 1,  2, 0, 0, 0, 0, 0, 0, 0);
        // Relock, then freeze the bus with en=0 mid-lap and resume.
        add(1, 4'b0001, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0100, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1000, 2, 0,  3, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 4'b0010, 0, 0,  1, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            add(0, 4'b0010, 0, 0,  1, 1, 0, 0, 0, 0, 1, 0);
        end
        add(1, 4'b0100, 1, 0,  2, 1, 0, 0, 0, 0, 1, 0);
        add(1, 4'b1000, 2, 0,  3, 1, 0, 0, 0, 0, 1, 0);
        add(1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 0, 2, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst_v = '{en: 1'b0, st: 4'b0000, oc: 2'b00, clr: 1'b0, dec: 2'd0, lk: 1'b0, eoh: 1'b0,
                  eseq: 1'b0, ecode: 1'b0, stk: 1'b0, lap: 4'd0, errc: 4'd0};
        check("reset", rst_v);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Lap counter wraps 15 -> 0 with CNT_W=4.
        for (int l = 3; l <= 16; l++) begin
            step($sformatf("lap%0d_s1", l), 1, 4'b0010, 0, 0,  1, 1, 0, 0, 0, 0, l - 1, 0);
            step($sformatf("lap%0d_s2", l), 1, 4'b0100, 1, 0,  2, 1, 0, 0, 0, 0, l - 1, 0);
            step($sformatf("lap%0d_s3", l), 1, 4'b1000, 2, 0,  3, 1, 0, 0, 0, 0, l - 1, 0);
            step($sformatf("lap%0d_idle", l), 1, 4'b0001, 3, 0,  0, 1, 0, 0, 0, 0, l % 16, 0);
        end

        // Error counter saturates at 15 after 20 consecutive error cycles.
        for (int k = 1; k <= 20; k++) begin
            step($sformatf("sat%0d", k), 1, 4'b0000, 0, 0,  0, 0, 1, 0, 0, 1, 0, (k < 15) ? k : 15);
        end

        // Asynchronous reset mid-sequence, then HUNT must ignore a non-IDLE sample.
        step("pre_rst_idle", 1, 4'b0001, 3, 0,  0, 0, 0, 0, 0, 1, 0, 15);
        step("pre_rst_s1",   1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 1, 0, 15);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("async_reset", rst_v);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst_s2",   1, 4'b0100, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst_idle", 1, 4'b0001, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst_s1",   1, 4'b0010, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
